// File: rtl/shift_frame_scheduler_if.sv
// Bundle of the requester handshakes and the serial output of shift_frame_scheduler.
interface shift_frame_scheduler_if #(
  parameter int unsigned WIDTH = 8
);
  logic             req0;
  logic [WIDTH-1:0] data0;
  logic             gnt0;
  logic             req1;
  logic [WIDTH-1:0] data1;
  logic             gnt1;
  logic             sOut;
  logic             sValid;
  logic             done;
  logic             busy;
  logic             owner;

  // Requester / environment side
  modport master (
    output req0, data0, req1, data1,
    input  gnt0, gnt1, sOut, sValid, done, busy, owner
  );

  // Scheduler side
  modport slave (
    input  req0, data0, req1, data1,
    output gnt0, gnt1, sOut, sValid, done, busy, owner
  );
endinterface

// File: rtl/shift_frame_scheduler.sv
// Round-robin arbiter between two word requesters feeding one MSB-first serial
// shift-out path, with framing (sValid), end-of-frame pulse and enforced idle gap.
module shift_frame_scheduler #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GAP   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  shift_frame_scheduler_if.slave bus
);

  localparam int unsigned CNT_W    = $clog2(WIDTH);
  localparam int unsigned GAP_W    = 4;
  localparam int unsigned GAP_LAST = (GAP == 0) ? 0 : GAP - 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               last_gnt_q, last_gnt_d;
  logic               owner_q, owner_d;
  logic               gnt0_q, gnt0_d;
  logic               gnt1_q, gnt1_d;
  logic               done_q, done_d;
  logic               sout_q, sout_d;
  logic               svalid_q, svalid_d;
  logic               busy_q, busy_d;
  logic               win;

  // State and registered outputs; reset clears everything, arbiter favours req0 next
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      gap_cnt_q  <= '0;
      last_gnt_q <= 1'b1;
      owner_q    <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      done_q     <= 1'b0;
      sout_q     <= 1'b0;
      svalid_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      last_gnt_q <= last_gnt_d;
      owner_q    <= owner_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      done_q     <= done_d;
      sout_q     <= sout_d;
      svalid_q   <= svalid_d;
      busy_q     <= busy_d;
    end
  end

  // Next state: arbitrate in IDLE, shift out the frame, then hold the idle gap
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    gap_cnt_d  = gap_cnt_q;
    last_gnt_d = last_gnt_q;
    owner_d    = owner_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    done_d     = 1'b0;
    win        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req0 || bus.req1) begin
          // With both pending, the one not served last time wins
          win        = (bus.req0 && bus.req1) ? ~last_gnt_q : bus.req1;
          shift_d    = win ? bus.data1 : bus.data0;
          owner_d    = win;
          last_gnt_d = win;
          cnt_d      = '0;
          gnt0_d     = ~win;
          gnt1_d     = win;
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shift_d = shift_q << 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          done_d    = 1'b1;
          gap_cnt_d = '0;
          state_d   = (GAP == 0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q + 4'd1;
        if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    svalid_d = (state_d == S_SHIFT);
    sout_d   = svalid_d & shift_d[WIDTH-1];
    busy_d   = (state_d != S_IDLE);
  end

  // Drive the bus from the output flops
  assign bus.gnt0   = gnt0_q;
  assign bus.gnt1   = gnt1_q;
  assign bus.sOut   = sout_q;
  assign bus.sValid = svalid_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;
  assign bus.owner  = owner_q;

endmodule

// File: tb/tb_shift_frame_scheduler.sv
// Bench for shift_frame_scheduler: three instances (GAP = 1, 0, 3) share one
// stimulus stream; each is compared every cycle against a frame-level model that
// expands each grant into the expected per-cycle output sequence.
`timescale 1ns/1ps
module tb_shift_frame_scheduler;

  localparam int unsigned WIDTH = 8;
  localparam int          NI    = 3;
  localparam logic [11:0] GAPS  = {4'd3, 4'd0, 4'd1};

  typedef struct packed {
    logic gnt0;
    logic gnt1;
    logic sout;
    logic svalid;
    logic done;
    logic busy;
    logic owner;
  } obs_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0, req1;
  logic [WIDTH-1:0] data0, data1;

  logic [NI-1:0] o_gnt0, o_gnt1, o_sout, o_svalid, o_done, o_busy, o_owner;

  int checks   = 0;
  int failures = 0;

  obs_t q   [NI][$];
  obs_t cur [NI];
  logic last_w [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    shift_frame_scheduler_if #(.WIDTH(WIDTH)) bus ();

    assign bus.req0  = req0;
    assign bus.req1  = req1;
    assign bus.data0 = data0;
    assign bus.data1 = data1;

    assign o_gnt0[g]   = bus.gnt0;
    assign o_gnt1[g]   = bus.gnt1;
    assign o_sout[g]   = bus.sOut;
    assign o_svalid[g] = bus.sValid;
    assign o_done[g]   = bus.done;
    assign o_busy[g]   = bus.busy;
    assign o_owner[g]  = bus.owner;

    shift_frame_scheduler #(
      .WIDTH(WIDTH),
      .GAP  (int'(GAPS[g*4 +: 4]))
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );
  end

  function automatic int gap_of(input int i);
    return int'(GAPS[i*4 +: 4]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      q[i].delete();
      cur[i]    = '0;
      last_w[i] = 1'b1;
    end
  endtask

  // One clock edge of the reference: a grant in an idle cycle queues the whole frame
  task automatic model_edge();
    obs_t             e;
    logic             w;
    logic [WIDTH-1:0] word;
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NI; i++) begin
      if (!cur[i].busy && (req0 || req1)) begin
        w         = (req0 && req1) ? ~last_w[i] : req1;
        last_w[i] = w;
        word      = w ? data1 : data0;
        for (int b = WIDTH - 1; b >= 0; b--) begin
          e        = '0;
          e.gnt0   = (b == WIDTH - 1) && !w;
          e.gnt1   = (b == WIDTH - 1) && w;
          e.sout   = word[b];
          e.svalid = 1'b1;
          e.busy   = 1'b1;
          e.owner  = w;
          q[i].push_back(e);
        end
        e       = '0;
        e.done  = 1'b1;
        e.busy  = (gap_of(i) > 0);
        e.owner = w;
        q[i].push_back(e);
        for (int j = 1; j < gap_of(i); j++) begin
          e       = '0;
          e.busy  = 1'b1;
          e.owner = w;
          q[i].push_back(e);
        end
      end
      if (q[i].size() > 0) cur[i] = q[i].pop_front();
      else                 cur[i] = '0;
    end
  endtask

  task automatic check_all(input string tag);
    obs_t o, x;
    for (int i = 0; i < NI; i++) begin
      o.gnt0   = o_gnt0[i];
      o.gnt1   = o_gnt1[i];
      o.sout   = o_sout[i];
      o.svalid = o_svalid[i];
      o.done   = o_done[i];
      o.busy   = o_busy[i];
      o.owner  = o_owner[i];
      x        = cur[i];
      if (!x.busy) begin
        o.owner = 1'b0;
        x.owner = 1'b0;
      end
      checks++;
      assert (o === x) else begin
        failures++;
        $error("FAIL %s inst=%0d gap=%0d observed{g0,g1,so,sv,dn,bz,ow}=%b expected=%b",
               tag, i, gap_of(i), o, x);
      end
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic run(input int n, input string tag);
    for (int k = 0; k < n; k++) step(tag);
  endtask

  // Reset asserted between edges: outputs must clear with no clock edge
  task automatic async_reset_pulse(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all({tag, "_async"});
    @(posedge clk);
    @(negedge clk);
    check_all({tag, "_hold"});
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    data0 = '0;
    data1 = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst = 1'b0;
    run(2, "idle");

    // Single request, word A5; data0 changes right after the grant edge
    req0  = 1'b1;
    data0 = 8'hA5;
    step("a5_grant");
    req0  = 1'b0;
    data0 = 8'h00;
    run(14, "a5_frame");

    // Both requesting from an idle start: alternating F0 / 0F frames
    req0  = 1'b1;
    req1  = 1'b1;
    data0 = 8'hF0;
    data1 = 8'h0F;
    run(60, "rr_both");

    // Requester 1 alone, back-to-back frames
    req0 = 1'b0;
    run(40, "req1_only");
    req1 = 1'b0;
    run(15, "drain");

    // Reset during bit 3 of a C3 frame, req0 still held afterwards
    req0  = 1'b1;
    data0 = 8'hC3;
    step("c3_grant");
    run(2, "c3_bits");
    async_reset_pulse("c3_rst");
    run(12, "c3_restart");
    req0 = 1'b0;
    run(15, "c3_drain");

    // req0 pulsed while busy is lost; data1 changed mid-frame is ignored
    req1  = 1'b1;
    data1 = 8'h3C;
    step("pulse_grant");
    req1 = 1'b0;
    run(2, "pulse_bits");
    req0 = 1'b1;
    step("pulse_req0");
    req0  = 1'b0;
    data1 = 8'hFF;
    run(20, "pulse_frame");

    // Randomized traffic with persistent requests and occasional resets
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 5) == 0) req0 = ~req0;
      if ($urandom_range(0, 5) == 0) req1 = ~req1;
      data0 = WIDTH'($urandom);
      data1 = WIDTH'($urandom);
      step("random");
      if ($urandom_range(0, 299) == 0) async_reset_pulse("rand_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
